// File: rtl/clk_en_scheduler.sv
// Shared prescaler that hands out power-of-two clock-enable strobes.
// Rate updates issued while counting are deferred to the next wrap.
module clk_en_scheduler #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [2:0]        cfg_ch,
   input  logic [2:0]        cfg_sel,
   output logic [NUM_CH-1:0] tick,
   output logic              wrap,
   output logic              busy,
   output logic [CNT_W-1:0]  cnt_o
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STOP
   } state_e;

   localparam logic [2:0] SEL_MAX = 3'(CNT_W);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;

   logic [2:0] sel_q [NUM_CH];
   logic [2:0] sel_d [NUM_CH];
   logic       pend_q, pend_d;
   logic       done_q, done_d;
   logic [2:0] pch_q, pch_d;
   logic [2:0] psel_q, psel_d;

   logic       active;
   logic       wrap_c;
   logic       xfer;
   logic [2:0] sel_clamp;

   assign active    = (state_q != IDLE);
   assign wrap_c    = active && (cnt_q == '1);
   assign sel_clamp = (cfg_sel > SEL_MAX) ? SEL_MAX : cfg_sel;
   assign xfer      = cfg_valid && cfg_ready;

   function automatic logic [CNT_W-1:0] mask_f(input logic [2:0] s);
      logic [CNT_W-1:0] m;
      for (int b = 0; b < CNT_W; b++) begin
         m[b] = (b < int'(s));
      end
      return m;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (run) state_q <= RUN;
            end
            RUN: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (!run) state_q <= STOP;
            end
            STOP: begin
               if (run) begin
                  state_q <= RUN;
                  cnt_q   <= cnt_q + CNT_W'(1);
               end else if (cnt_q == '1) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // done_q holds cfg_ready low for one extra cycle after the wrap write
   always_comb begin
      pend_d = pend_q;
      done_d = 1'b0;
      pch_d  = pch_q;
      psel_d = psel_q;
      for (int i = 0; i < NUM_CH; i++) begin
         sel_d[i] = sel_q[i];
      end
      if (xfer && !active) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == 3'(i)) sel_d[i] = sel_clamp;
         end
      end else if (xfer) begin
         pend_d = 1'b1;
         pch_d  = cfg_ch;
         psel_d = sel_clamp;
      end
      if (pend_q && wrap_c) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (pch_q == 3'(i)) sel_d[i] = psel_q;
         end
         pend_d = 1'b0;
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= 1'b0;
         done_q <= 1'b0;
         pch_q  <= '0;
         psel_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            sel_q[i] <= '0;
         end
      end else begin
         pend_q <= pend_d;
         done_q <= done_d;
         pch_q  <= pch_d;
         psel_q <= psel_d;
         for (int i = 0; i < NUM_CH; i++) begin
            sel_q[i] <= sel_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         tick[i] = active && (sel_q[i] != 3'd0) &&
                   ((cnt_q & mask_f(sel_q[i])) == mask_f(sel_q[i]));
      end
   end

   assign cfg_ready = !pend_q && !done_q;
   assign wrap      = wrap_c;
   assign busy      = active;
   assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_clk_en_scheduler.sv
// Directed bench for clk_en_scheduler: rates, deferred updates,
// stop/restart and reset with an update pending.
module tb_clk_en_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [2:0] cfg_ch;
   logic [2:0] cfg_sel;
   logic [3:0] tick;
   logic       wrap;
   logic       busy;
   logic [4:0] cnt_o;

   int total = 0;
   int bad   = 0;
   int esel [4];
   int ecnt;

   clk_en_scheduler #(.NUM_CH(4), .CNT_W(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_ch   (cfg_ch),
      .cfg_sel  (cfg_sel),
      .tick     (tick),
      .wrap     (wrap),
      .busy     (busy),
      .cnt_o    (cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (ecnt=%0d)",
                  tag, got, exp, ecnt);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] exp_tick(input int c);
      logic [3:0] t;
      for (int i = 0; i < 4; i++) begin
         int p;
         p    = 1 << esel[i];
         t[i] = (esel[i] != 0) && ((c % p) == (p - 1));
      end
      return t;
   endfunction

   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         chk("cnt", 32'(cnt_o), 32'(ecnt));
         chk("tick", 32'(tick), 32'(exp_tick(ecnt)));
         chk("wrap", 32'(wrap), 32'(ecnt == 31));
         chk("busy", 32'(busy), 32'd1);
         step();
         ecnt = (ecnt + 1) % 32;
      end
   endtask

   task automatic idle_write(input int ch, input int s);
      cfg_valid = 1'b1;
      cfg_ch    = 3'(ch);
      cfg_sel   = 3'(s);
      step();
      cfg_valid = 1'b0;
      chk("idle_ready", 32'(cfg_ready), 32'd1);
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; cfg_valid = 1'b0;
      cfg_ch = '0; cfg_sel = '0; ecnt = 0;
      for (int i = 0; i < 4; i++) esel[i] = 0;
      step(); step();
      rst = 1'b0;
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd1);
      chk("rst_cnt", 32'(cnt_o), 32'd0);

      idle_write(0, 1); esel[0] = 1;
      idle_write(1, 2); esel[1] = 2;
      idle_write(2, 3); esel[2] = 3;
      idle_write(3, 5); esel[3] = 5;
      chk("idle_cnt", 32'(cnt_o), 32'd0);
      chk("idle_tick", 32'(tick), 32'd0);

      run = 1'b1;
      step();
      ecnt = 0;
      run_cycles(64);

      // deferred update requested at cnt=10
      run_cycles(10);
      cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_sel = 3'd3;
      chk("ready_c10", 32'(cfg_ready), 32'd1);
      run_cycles(1);
      cfg_valid = 1'b0;
      chk("ready_c11", 32'(cfg_ready), 32'd0);
      run_cycles(20);
      chk("ready_c31", 32'(cfg_ready), 32'd0);
      run_cycles(1);
      esel[0] = 3;
      chk("ready_c0", 32'(cfg_ready), 32'd0);
      run_cycles(1);
      chk("ready_c1", 32'(cfg_ready), 32'd1);
      run_cycles(31);

      // request in the wrap cycle, with a clamped select
      run_cycles(31);
      cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_sel = 3'd7;
      run_cycles(1);
      cfg_valid = 1'b0;
      for (int i = 0; i < 32; i++) begin
         chk("ready_low33", 32'(cfg_ready), 32'd0);
         run_cycles(1);
      end
      esel[1] = 5;
      chk("ready_low33", 32'(cfg_ready), 32'd0);
      run_cycles(1);
      chk("ready_back", 32'(cfg_ready), 32'd1);
      run_cycles(31);

      // out-of-range channel
      cfg_valid = 1'b1; cfg_ch = 3'd6; cfg_sel = 3'd1;
      run_cycles(1);
      cfg_valid = 1'b0;
      chk("oor_ready_c1", 32'(cfg_ready), 32'd0);
      run_cycles(31);
      chk("oor_ready_c0", 32'(cfg_ready), 32'd0);
      run_cycles(1);
      chk("oor_ready_c1b", 32'(cfg_ready), 32'd1);

      // stop request at cnt=5
      run_cycles(4);
      run = 1'b0;
      run_cycles(27);
      for (int i = 0; i < 5; i++) begin
         chk("stop_busy", 32'(busy), 32'd0);
         chk("stop_cnt", 32'(cnt_o), 32'd0);
         chk("stop_tick", 32'(tick), 32'd0);
         chk("stop_wrap", 32'(wrap), 32'd0);
         step();
      end

      // restart, stop, re-raise at cnt=20
      run = 1'b1;
      step();
      ecnt = 0;
      run_cycles(5);
      run = 1'b0;
      run_cycles(15);
      run = 1'b1;
      run_cycles(20);

      // reset with an update pending
      cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_sel = 3'd1;
      run_cycles(1);
      cfg_valid = 1'b0;
      chk("pend_ready", 32'(cfg_ready), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      run = 1'b0;
      ecnt = 0;
      for (int i = 0; i < 4; i++) esel[i] = 0;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_tick", 32'(tick), 32'd0);
      chk("mrst_ready", 32'(cfg_ready), 32'd1);
      chk("mrst_cnt", 32'(cnt_o), 32'd0);
      run = 1'b1;
      step();
      run_cycles(40);
      run = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
